// File: rtl/writeback_stage_reg_pkg.sv
// Shared encodings for the MEM/WB writeback stage: result sources, load types, control layout.
package writeback_stage_reg_pkg;

  localparam int unsigned CTRL_W         = 6;
  localparam int unsigned CTRL_REG_WRITE = 5;
  localparam int unsigned CTRL_SRC_HI    = 4;
  localparam int unsigned CTRL_SRC_LO    = 3;
  localparam int unsigned CTRL_LT_HI     = 2;
  localparam int unsigned CTRL_LT_LO     = 0;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC4 = 2'b10,
    SRC_IMM = 2'b11
  } result_src_e;

  // funct3 of the load; 011 and 111 are not named and pass raw data through
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_type_e;

  // Packed view of controlsignals, MSB first so it overlays the 6-bit bus directly
  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic [2:0]  load_type;
  } ctrl_t;

  // Unpack the raw control bus into its fields
  function automatic ctrl_t ctrl_unpack(input logic [CTRL_W-1:0] raw);
    ctrl_t c;
    c.reg_write  = raw[CTRL_REG_WRITE];
    c.result_src = result_src_e'(raw[CTRL_SRC_HI:CTRL_SRC_LO]);
    c.load_type  = raw[CTRL_LT_HI:CTRL_LT_LO];
    return c;
  endfunction

endpackage

// File: rtl/writeback_stage_reg_if.sv
// Memory-stage to writeback-stage bundle: MEM-side inputs and register-file-side outputs.
interface writeback_stage_reg_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  import writeback_stage_reg_pkg::*;

  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic [WIDTH-1:0]      readData;
  logic [WIDTH-1:0]      ALUResult;
  logic [WIDTH-1:0]      pcPlus4;
  logic [WIDTH-1:0]      immExt;
  logic [CTRL_W-1:0]     controlsignals;
  logic [REG_ADDR_W-1:0] Rd;

  logic                  RegWrite;
  logic [WIDTH-1:0]      Writeback;
  logic [REG_ADDR_W-1:0] rd;
  logic                  wb_valid;
  logic [CNT_W-1:0]      retired;

  // Memory stage / pipeline control side
  modport master (
    output stall, flush, in_valid, readData, ALUResult, pcPlus4, immExt,
           controlsignals, Rd,
    input  RegWrite, Writeback, rd, wb_valid, retired
  );

  // Writeback stage side
  modport slave (
    input  stall, flush, in_valid, readData, ALUResult, pcPlus4, immExt,
           controlsignals, Rd,
    output RegWrite, Writeback, rd, wb_valid, retired
  );

endinterface

// File: rtl/writeback_stage_reg_load_extender.sv
// RISC-V load data extraction: byte/half/word select by offset with sign or zero extension.
module load_extender
  import writeback_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] readData,
  input  logic [1:0]       off,
  input  logic [2:0]       load_type,
  output logic [WIDTH-1:0] ext
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] word_c;

  // Pick the addressed byte, halfword and the low word of the memory word
  always_comb begin
    byte_c = readData[7:0];
    case (off)
      2'd0:    byte_c = readData[7:0];
      2'd1:    byte_c = readData[15:8];
      2'd2:    byte_c = readData[23:16];
      default: byte_c = readData[31:24];
    endcase
    // off[0] is deliberately ignored for halfwords; misalignment is not trapped
    half_c = off[1] ? readData[31:16] : readData[15:0];
    word_c = readData[31:0];
  end

  // Extend the selected piece according to funct3
  always_comb begin
    ext = readData;
    case (load_type)
      LB:      ext = WIDTH'($signed(byte_c));
      LBU:     ext = WIDTH'(byte_c);
      LH:      ext = WIDTH'($signed(half_c));
      LHU:     ext = WIDTH'(half_c);
      LW:      ext = WIDTH'($signed(word_c));
      LWU:     ext = WIDTH'(word_c);
      default: ext = readData;
    endcase
  end

endmodule

// File: rtl/writeback_stage_reg.sv
// MEM/WB pipeline register with result select, load extension, x0 suppression and retire counter.
module writeback_stage_reg
  import writeback_stage_reg_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input logic                 clk,
  input logic                 rst,
  writeback_stage_reg_if.slave wb
);

  logic                  valid_q;
  ctrl_t                 ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [WIDTH-1:0]      alu_q;
  logic [WIDTH-1:0]      rdata_q;
  logic [WIDTH-1:0]      pc4_q;
  logic [WIDTH-1:0]      imm_q;
  logic [CNT_W-1:0]      retired_q;

  logic [WIDTH-1:0]      load_c;
  logic [WIDTH-1:0]      result_c;
  logic                  advance_c;

  assign advance_c = !wb.flush && !wb.stall;

  // MEM/WB register: flush inserts a cleared bubble, stall holds, otherwise load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
    end else if (wb.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      pc4_q   <= '0;
      imm_q   <= '0;
    end else if (!wb.stall) begin
      valid_q <= wb.in_valid;
      ctrl_q  <= ctrl_unpack(wb.controlsignals);
      rd_q    <= wb.Rd;
      alu_q   <= wb.ALUResult;
      rdata_q <= wb.readData;
      pc4_q   <= wb.pcPlus4;
      imm_q   <= wb.immExt;
    end
  end

  // Count instructions entering writeback; wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (advance_c && wb.in_valid) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  load_extender #(
    .WIDTH(WIDTH)
  ) u_load_extender (
    .readData (rdata_q),
    .off      (alu_q[1:0]),
    .load_type(ctrl_q.load_type),
    .ext      (load_c)
  );

  // Writeback source select, driven only by registered fields
  always_comb begin
    result_c = alu_q;
    case (ctrl_q.result_src)
      SRC_ALU: result_c = alu_q;
      SRC_MEM: result_c = load_c;
      SRC_PC4: result_c = pc4_q;
      SRC_IMM: result_c = imm_q;
      default: result_c = alu_q;
    endcase
  end

  assign wb.Writeback = result_c;
  assign wb.RegWrite  = valid_q && ctrl_q.reg_write && (rd_q != '0);
  assign wb.rd        = rd_q;
  assign wb.wb_valid  = valid_q;
  assign wb.retired   = retired_q;

endmodule

// File: tb/tb_writeback_stage_reg.sv
// Directed bench for writeback_stage_reg: vector table plus stall/flush, wrap and reset sequences.
module tb_writeback_stage_reg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 4;

  logic clk;
  logic rst;

  writeback_stage_reg_if #(
    .WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)
  ) bus ();

  writeback_stage_reg #(
    .WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic [5:0]  ctrl;
    logic [4:0]  rd_in;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        e_rw;
    logic [31:0] e_wb;
    logic [4:0]  e_rd;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;
  logic [3:0] exp_ret;

  function automatic vec_t mk(input logic fl, input logic st, input logic v,
                              input logic [5:0] c, input logic [4:0] r,
                              input logic [31:0] rdat, input logic [31:0] a,
                              input logic [31:0] p, input logic [31:0] im,
                              input logic erw, input logic [31:0] ewb,
                              input logic [4:0] erd, input logic ev);
    vec_t x;
    x.flush = fl; x.stall = st; x.in_valid = v; x.ctrl = c; x.rd_in = r;
    x.rdata = rdat; x.alu = a; x.pc4 = p; x.imm = im;
    x.e_rw = erw; x.e_wb = ewb; x.e_rd = erd; x.e_v = ev;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic erw, input logic [31:0] ewb,
                         input logic [4:0] erd, input logic ev, input logic [3:0] eret);
    chk({nm, ".RegWrite"},  32'(bus.RegWrite), 32'(erw));
    chk({nm, ".Writeback"}, bus.Writeback,     ewb);
    chk({nm, ".rd"},        32'(bus.rd),       32'(erd));
    chk({nm, ".wb_valid"},  32'(bus.wb_valid), 32'(ev));
    chk({nm, ".retired"},   32'(bus.retired),  32'(eret));
  endtask

  task automatic drive(input logic fl, input logic st, input logic v, input logic [5:0] c,
                       input logic [4:0] r, input logic [31:0] rdat, input logic [31:0] a,
                       input logic [31:0] p, input logic [31:0] im);
    bus.flush = fl; bus.stall = st; bus.in_valid = v; bus.controlsignals = c;
    bus.Rd = r; bus.readData = rdat; bus.ALUResult = a; bus.pcPlus4 = p; bus.immExt = im;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!rst && !bus.flush && !bus.stall && bus.in_valid) exp_ret = exp_ret + 4'd1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    exp_ret = 4'd0;
    rst = 1'b1;
    drive(0, 0, 0, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // ctrl = {reg_write, result_src[1:0], load_type[2:0]}
    vecs.push_back(mk(0,0,1, 6'h20, 5'd5,  32'h0,        32'h0000_1234, 32'h0, 32'h0, 1, 32'h0000_1234, 5'd5, 1));
    vecs.push_back(mk(0,0,1, 6'h28, 5'd6,  32'h80FF_7F01, 32'h0000_1001, 32'h0, 32'h0, 1, 32'h0000_007F, 5'd6, 1));
    vecs.push_back(mk(0,0,1, 6'h28, 5'd6,  32'h80FF_7F01, 32'h0000_1003, 32'h0, 32'h0, 1, 32'hFFFF_FF80, 5'd6, 1));
    vecs.push_back(mk(0,0,1, 6'h28, 5'd6,  32'h80FF_7F01, 32'h0000_1000, 32'h0, 32'h0, 1, 32'h0000_0001, 5'd6, 1));
    vecs.push_back(mk(0,0,1, 6'h2C, 5'd7,  32'h80FF_7F01, 32'h0000_1002, 32'h0, 32'h0, 1, 32'h0000_00FF, 5'd7, 1));
    vecs.push_back(mk(0,0,1, 6'h2C, 5'd7,  32'h80FF_7F01, 32'h0000_1003, 32'h0, 32'h0, 1, 32'h0000_0080, 5'd7, 1));
    vecs.push_back(mk(0,0,1, 6'h29, 5'd8,  32'h80FF_7F01, 32'h0000_1002, 32'h0, 32'h0, 1, 32'hFFFF_80FF, 5'd8, 1));
    vecs.push_back(mk(0,0,1, 6'h2D, 5'd8,  32'h80FF_7F01, 32'h0000_1000, 32'h0, 32'h0, 1, 32'h0000_7F01, 5'd8, 1));
    vecs.push_back(mk(0,0,1, 6'h2D, 5'd8,  32'h80FF_7F01, 32'h0000_1003, 32'h0, 32'h0, 1, 32'h0000_80FF, 5'd8, 1));
    vecs.push_back(mk(0,0,1, 6'h2A, 5'd9,  32'h80FF_7F01, 32'h0000_1000, 32'h0, 32'h0, 1, 32'h80FF_7F01, 5'd9, 1));
    vecs.push_back(mk(0,0,1, 6'h2E, 5'd9,  32'h80FF_7F01, 32'h0000_1000, 32'h0, 32'h0, 1, 32'h80FF_7F01, 5'd9, 1));
    vecs.push_back(mk(0,0,1, 6'h2B, 5'd9,  32'h80FF_7F01, 32'h0000_1003, 32'h0, 32'h0, 1, 32'h80FF_7F01, 5'd9, 1));
    vecs.push_back(mk(0,0,1, 6'h20, 5'd0,  32'h0,        32'h0000_0055, 32'h0, 32'h0, 0, 32'h0000_0055, 5'd0, 1));
    vecs.push_back(mk(0,0,1, 6'h30, 5'd1,  32'h0,        32'h0000_0010, 32'h104, 32'h0, 1, 32'h0000_0104, 5'd1, 1));
    vecs.push_back(mk(0,0,1, 6'h38, 5'd2,  32'h0,        32'h0000_0010, 32'h0, 32'hABCD_E000, 1, 32'hABCD_E000, 5'd2, 1));
    vecs.push_back(mk(0,0,1, 6'h00, 5'd7,  32'h0,        32'h0000_0009, 32'h0, 32'h0, 0, 32'h0000_0009, 5'd7, 1));
    vecs.push_back(mk(0,0,0, 6'h20, 5'd3,  32'h0,        32'h0000_0077, 32'h0, 32'h0, 0, 32'h0000_0077, 5'd3, 0));
    vecs.push_back(mk(1,0,1, 6'h20, 5'd4,  32'h0,        32'h0000_0066, 32'h0, 32'h0, 0, 32'h0000_0000, 5'd0, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 32'h0, 5'd0, 0, 4'd0);
    rst = 1'b0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].stall, vecs[i].in_valid, vecs[i].ctrl, vecs[i].rd_in,
            vecs[i].rdata, vecs[i].alu, vecs[i].pc4, vecs[i].imm);
      cyc();
      chk_out($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wb, vecs[i].e_rd, vecs[i].e_v, exp_ret);
    end

    // Stall holds a loaded instruction for three cycles, then flush wins over stall
    drive(0, 0, 1, 6'h20, 5'd9, 32'h0, 32'h0000_CAFE, 32'h0, 32'h0);
    cyc();
    chk_out("stall_load", 1, 32'h0000_CAFE, 5'd9, 1, exp_ret);
    drive(0, 1, 1, 6'h38, 5'd1, 32'h0, 32'h0000_DEAD, 32'h0, 32'h1111_0000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out($sformatf("stall%0d", k), 1, 32'h0000_CAFE, 5'd9, 1, exp_ret);
    end
    drive(1, 1, 1, 6'h38, 5'd1, 32'h0, 32'h0000_DEAD, 32'h0, 32'h1111_0000);
    cyc();
    chk_out("stall_flush", 0, 32'h0, 5'd0, 0, exp_ret);

    // Counter wrap with a 4-bit counter: 17 instructions leave retired at 1
    drive(0, 0, 0, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    chk("wrap_rst.retired", 32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = 4'd0;
    drive(0, 0, 1, 6'h20, 5'd2, 32'h0, 32'h0000_0042, 32'h0, 32'h0);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 16) chk("wrap16.retired", 32'(bus.retired), 32'd0);
    end
    chk("wrap17.retired", 32'(bus.retired), 32'd1);
    chk_out("wrap17", 1, 32'h0000_0042, 5'd2, 1, 4'd1);

    // Asynchronous reset between edges clears outputs before the next edge
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 32'h0, 5'd0, 0, 4'd0);
    @(posedge clk);
    #1;
    chk_out("rst_hold", 0, 32'h0, 5'd0, 0, 4'd0);
    rst = 1'b0;
    drive(0, 0, 0, 6'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage_reg.md
Name: writeback_stage_reg

Overview:
- Parametrised, registered successor of the combinational writeback stage.
- Holds the MEM/WB pipeline register, with valid, stall and flush.
- Selects the writeback result from four sources and applies RISC-V load byte/half extraction with sign or zero extension.
- Suppresses writes to x0 and keeps a retired-instruction counter. Sits between the memory stage and the register file.

Parameters:
- WIDTH, 32, datapath width in bits (32 or 64).
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the MEM/WB register contents.
- flush  input  1  load a bubble into the MEM/WB register.
- in_valid  input  1  memory-stage instruction is valid.
- readData  input  WIDTH  raw data-memory word.
- ALUResult  input  WIDTH  ALU result; low 2 bits are the load byte offset.
- pcPlus4  input  WIDTH  link value for JAL/JALR.
- immExt  input  WIDTH  extended immediate for LUI.
- controlsignals  input  6  [5] reg_write, [4:3] result_src, [2:0] load_type (funct3).
- Rd  input  REG_ADDR_W  destination register.
- RegWrite  output  1  register-file write enable.
- Writeback  output  WIDTH  data to the register file.
- rd  output  REG_ADDR_W  registered destination register.
- wb_valid  output  1  registered valid.
- retired  output  CNT_W  count of instructions that entered WB.

Behaviour:
- Reset (asynchronous, rst=1): every register clears. Outputs read RegWrite=0, Writeback=0, rd=0, wb_valid=0, retired=0. Rising edges of clk are ignored while rst=1.
- Register update, priority flush > stall > load, evaluated on the clk rising edge:
  - flush=1: wb_valid<=0 and reg_write<=0; the other fields are don't-care and cleared to 0.
  - stall=1, flush=0: all fields hold.
  - otherwise: all fields load; wb_valid<=in_valid.
- Latency: 1 cycle from input to outputs. Writeback and RegWrite are combinational from the registered fields only; there is no input-to-output combinational path.
- result_src selects the writeback value:
  - 00: ALUResult
  - 01: extracted load data
  - 10: pcPlus4
  - 11: immExt
- Load extraction, using the registered ALUResult[1:0] as offset `off`:
  - load_type 000 (LB): sign-extend byte `off`, i.e. readData[8*off+7 : 8*off].
  - 100 (LBU): zero-extend byte `off`.
  - 001 (LH): sign-extend halfword off[1].
  - 101 (LHU): zero-extend halfword off[1]; off[0] is ignored and misalignment is not trapped.
  - 010 (LW): full word; sign-extended when WIDTH=64.
  - 110 (LWU): full word, zero-extended.
  - 011 and 111: raw readData passes through unchanged.
- RegWrite = wb_valid & reg_write & (rd != 0). Writeback still shows the selected value when rd=0.
- During a stall the held instruction keeps asserting RegWrite. The write is idempotent, so this is safe.
- retired increments by 1 on each edge where flush=0, stall=0 and in_valid=1. It wraps from all-ones to 0.

Decomposition:
- Shared package holds:
  - RESULT_SRC codes: SRC_ALU, SRC_MEM, SRC_PC4, SRC_IMM.
  - LOAD_TYPE codes: LB, LH, LW, LBU, LHU, LWU.
  - controlsignals bit-position constants.
- One combinational sub-module, load_extender, with inputs (readData, off, load_type) and output the extended value. It is reused by any future cache path.

Test Plan:
- Reset mid-operation: drive valid traffic, then assert rst between clock edges. All outputs go to 0 immediately, before the next edge; retired=0.
- ALU write: ALUResult=0x0000_1234, src=00, reg_write=1, Rd=5. One cycle later: Writeback=0x1234, rd=5, RegWrite=1, retired=1.
- Load extension: readData=0x80FF_7F01 with ALUResult=0x..01 and offset 1. Required results:
  - LB gives 0x0000_007F.
  - offset 3 LB gives 0xFFFF_FF80.
  - LBU offset 2 gives 0x0000_00FF.
  - LH offset 2 gives 0xFFFF_80FF.
  - LHU offset 0 gives 0x0000_7F01.
- x0 suppression and other sources: Rd=0 with reg_write=1 gives RegWrite=0. src=10 with pcPlus4=0x104 gives Writeback=0x104. src=11 with immExt=0xABCDE000 gives Writeback=0xABCDE000.
- Stall then flush: a loaded instruction holds for 3 stalled cycles with retired unchanged. Then stall=1 and flush=1 together produce wb_valid=0 and RegWrite=0 on the next cycle.
- Counter wrap: CNT_W=4. 17 consecutive valid instructions give retired=1.
